// File: rtl/alu_sched_pkg.sv
// Shared types and default widths for the two-requester ALU scheduler.
package alu_sched_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester/response handshake bundle between client blocks and alu_scheduler.
interface alu_scheduler_if #(
  parameter int DATA_W = alu_sched_pkg::DATA_W_DEF,
  parameter int OP_W   = alu_sched_pkg::OP_W_DEF
);
  logic              req_0;
  logic              req_1;
  logic [DATA_W-1:0] in_1_0;
  logic [DATA_W-1:0] in_2_0;
  logic [DATA_W-1:0] in_1_1;
  logic [DATA_W-1:0] in_2_1;
  logic [OP_W-1:0]   control_0;
  logic [OP_W-1:0]   control_1;
  logic              gnt_0;
  logic              gnt_1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W:0]   rsp_data;

  modport master (
    output req_0, req_1, in_1_0, in_2_0, in_1_1, in_2_1, control_0, control_1, rsp_ready,
    input  gnt_0, gnt_1, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_0, req_1, in_1_0, in_2_0, in_1_1, in_2_1, control_0, control_1, rsp_ready,
    output gnt_0, gnt_1, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (advance && (|req))
      last <= grant[1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters: grant, execute, respond.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_scheduler_if.slave    bus,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W:0]   alu_out
);

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       issue;
  logic       rsp_id_q;
  logic [DATA_W:0] rsp_data_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req_1, bus.req_0}),
    .advance (issue),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_0 || bus.req_1) begin
          issue     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in_1    <= '0;
      alu_in_2    <= '0;
      alu_control <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (issue) begin
        alu_in_1    <= grant[1] ? bus.in_1_1    : bus.in_1_0;
        alu_in_2    <= grant[1] ? bus.in_2_1    : bus.in_2_0;
        alu_control <= grant[1] ? bus.control_1 : bus.control_0;
        rsp_id_q    <= grant[1];
      end
      if (state == EXEC)
        rsp_data_q <= alu_out;
    end
  end

  // The grant pulse coincides with EXEC; rsp_id already names the winner then.
  assign bus.gnt_0     = (state == EXEC) && !rsp_id_q;
  assign bus.gnt_1     = (state == EXEC) &&  rsp_id_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
